// File: rtl/riscv_v_writeback_pkg.sv
// -----------------------------------------------------------------------------
// riscv_v_writeback_pkg
// Shared types and constants for the vector write-back stage: vector data and
// vl/vstart/vtype types, the buffered result entry, the drain FSM states, and
// the per-bit merge-select helper used on the push path.
// -----------------------------------------------------------------------------
package riscv_v_writeback_pkg;

  localparam int RISCV_V_VLEN          = 128;
  localparam int RISCV_V_XLEN          = 32;
  localparam int RISCV_V_NUM_VREGS     = 32;
  localparam int RISCV_V_VREG_AW       = $clog2(RISCV_V_NUM_VREGS);
  localparam int RISCV_V_WB_FIFO_DEPTH = 2;
  // vl needs one extra bit so that vl == VLEN is representable
  localparam int RISCV_V_VL_W          = $clog2(RISCV_V_VLEN) + 1;

  typedef logic [RISCV_V_VLEN-1:0]    riscv_v_data_t;
  typedef riscv_v_data_t              riscv_v_wb_data_t;
  typedef logic [RISCV_V_VL_W-1:0]    riscv_v_vl_t;
  typedef logic [RISCV_V_VL_W-2:0]    riscv_v_vstart_t;
  typedef logic [RISCV_V_VREG_AW-1:0] riscv_v_vreg_t;
  typedef logic [4:0]                 riscv_v_xreg_t;
  typedef logic [RISCV_V_XLEN-1:0]    riscv_v_xdata_t;

  typedef struct packed {
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
  } riscv_v_vtype_t;

  typedef struct packed {
    riscv_v_wb_data_t data;
    riscv_v_vreg_t    vd;
    riscv_v_xreg_t    rd;
    riscv_v_xdata_t   int_data;
    logic             is_v2i;
  } riscv_v_wb_entry_t;

  // Per-bit selects: take_new picks the new result, set_ones forces 1,
  // neither keeps the old vd bit.
  typedef struct packed {
    riscv_v_data_t take_new;
    riscv_v_data_t set_ones;
  } riscv_v_merge_sel_t;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_HEAD = 1'b1
  } riscv_v_wb_state_t;

  // sew is log2 of the element width in bits (0 = one bit per element for
  // mask destinations, 3..6 for SEW 8..64). mask holds one bit per element.
  function automatic riscv_v_merge_sel_t riscv_v_tail_mask_merge(
    input logic [3:0]      sew,
    input riscv_v_vl_t     vl,
    input riscv_v_vstart_t vstart,
    input logic            vm,
    input logic            vta,
    input logic            vma,
    input riscv_v_data_t   mask
  );
    riscv_v_merge_sel_t sel;
    int unsigned        idx;
    sel = '0;
    for (int unsigned b = 0; b < RISCV_V_VLEN; b++) begin
      idx = b >> sew;
      if (idx < 32'(vstart)) begin
        // prestart elements are always undisturbed
        sel.take_new[b] = 1'b0;
      end else if (idx < 32'(vl)) begin
        if (vm || mask[idx[RISCV_V_VL_W-2:0]]) begin
          sel.take_new[b] = 1'b1;
        end else begin
          sel.set_ones[b] = vma;
        end
      end else begin
        sel.set_ones[b] = vta;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/riscv_v_writeback_if.sv
// -----------------------------------------------------------------------------
// riscv_v_writeback_if
// Execute -> write-back result handshake. The execute stage is the master
// (drives exe_valid and the result payload); write-back is the slave and
// returns exe_ready. vtype/vl/vstart travel with the result and are sampled
// by write-back on accept.
// -----------------------------------------------------------------------------
interface riscv_v_writeback_if;
  import riscv_v_writeback_pkg::*;

  logic             exe_valid;
  logic             exe_ready;
  riscv_v_wb_data_t alu_result_exe;
  riscv_v_data_t    mask_result_exe;
  riscv_v_data_t    old_vd_exe;
  riscv_v_data_t    mask_exe;
  logic             vm_exe;
  riscv_v_vreg_t    vd_exe;
  riscv_v_xreg_t    rd_exe;
  riscv_v_xdata_t   int_data_result_exe;
  logic             is_v2i_exe;
  logic             is_mask_dst_exe;
  riscv_v_vtype_t   vtype;
  riscv_v_vl_t      vl;
  riscv_v_vstart_t  vstart;

  modport master (
    output exe_valid, alu_result_exe, mask_result_exe, old_vd_exe, mask_exe,
           vm_exe, vd_exe, rd_exe, int_data_result_exe, is_v2i_exe,
           is_mask_dst_exe, vtype, vl, vstart,
    input  exe_ready
  );

  modport slave (
    input  exe_valid, alu_result_exe, mask_result_exe, old_vd_exe, mask_exe,
           vm_exe, vd_exe, rd_exe, int_data_result_exe, is_v2i_exe,
           is_mask_dst_exe, vtype, vl, vstart,
    output exe_ready
  );
endinterface

// File: rtl/riscv_v_writeback_merge.sv
// -----------------------------------------------------------------------------
// riscv_v_writeback_merge
// Combinational element merge on the push path. Combines the new result with
// the old vd contents according to vstart, vl, the v0 mask and vta/vma.
// Ports:
//   alu_result   in  vector result
//   mask_result  in  mask result (one bit per element), used when is_mask_dst
//   old_vd       in  prior vd contents
//   mask         in  v0 mask, one bit per element
//   vm           in  1 = unmasked
//   is_mask_dst  in  destination is a mask register
//   vtype/vl/vstart in  vector configuration
//   merged       out merged vd write data
// -----------------------------------------------------------------------------
module riscv_v_writeback_merge
  import riscv_v_writeback_pkg::*;
(
  input  riscv_v_wb_data_t alu_result,
  input  riscv_v_data_t    mask_result,
  input  riscv_v_data_t    old_vd,
  input  riscv_v_data_t    mask,
  input  logic             vm,
  input  logic             is_mask_dst,
  input  riscv_v_vtype_t   vtype,
  input  riscv_v_vl_t      vl,
  input  riscv_v_vstart_t  vstart,
  output riscv_v_data_t    merged
);

  logic [3:0]         sew_log2;
  riscv_v_data_t      new_data;
  riscv_v_merge_sel_t sel;

  // Mask destinations treat every bit as its own element
  always_comb begin
    if (is_mask_dst) begin
      sew_log2 = 4'd0;
      new_data = mask_result;
    end else begin
      sew_log2 = 4'd3 + {1'b0, vtype.vsew};
      new_data = alu_result;
    end
    sel    = riscv_v_tail_mask_merge(sew_log2, vl, vstart, vm,
                                     vtype.vta, vtype.vma, mask);
    merged = (new_data & sel.take_new) | sel.set_ones |
             (old_vd & ~sel.take_new & ~sel.set_ones);
  end

endmodule

// File: rtl/riscv_v_writeback.sv
// -----------------------------------------------------------------------------
// riscv_v_writeback
// Write-back stage of the vector pipeline. Accepts execute results over the
// exe interface, merges them against old vd on push, buffers them in a small
// FIFO and drains the head into the VRF or integer RF write port, one write
// per cycle, in order. The FIFO head is exported for forwarding.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   exe              result handshake (slave side)
//   vrf_ready        VRF write port free this cycle
//   vrf_we/waddr/wdata  registered VRF write port
//   int_we/waddr/wdata  registered integer RF write port
//   byp_valid/vd/data   FIFO head vector result for forwarding
// -----------------------------------------------------------------------------
module riscv_v_writeback
  import riscv_v_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH = RISCV_V_WB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_v_writeback_if.slave     exe,
  input  logic                   vrf_ready,
  output logic                   vrf_we,
  output riscv_v_vreg_t          vrf_waddr,
  output riscv_v_data_t          vrf_wdata,
  output logic                   int_we,
  output riscv_v_xreg_t          int_waddr,
  output riscv_v_xdata_t         int_wdata,
  output logic                   byp_valid,
  output riscv_v_vreg_t          byp_vd,
  output riscv_v_data_t          byp_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  riscv_v_wb_entry_t fifo_q [FIFO_DEPTH];
  riscv_v_wb_entry_t fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  riscv_v_wb_state_t state_q, state_d;

  logic              vrf_we_q, vrf_we_d;
  riscv_v_vreg_t     vrf_waddr_q, vrf_waddr_d;
  riscv_v_data_t     vrf_wdata_q, vrf_wdata_d;
  logic              int_we_q, int_we_d;
  riscv_v_xreg_t     int_waddr_q, int_waddr_d;
  riscv_v_xdata_t    int_wdata_q, int_wdata_d;

  logic              full;
  logic              push;
  logic              pop;
  riscv_v_data_t     merged;
  riscv_v_wb_entry_t new_entry;
  riscv_v_wb_entry_t head;

  // exe_ready depends only on the registered count, so a pop never frees
  // a slot for a push in the same cycle
  assign full          = (count_q == CNT_W'(FIFO_DEPTH));
  assign exe.exe_ready = ~full;
  assign push          = exe.exe_valid & ~full;
  assign head          = fifo_q[rd_ptr_q];

  riscv_v_writeback_merge u_merge (
    .alu_result  (exe.alu_result_exe),
    .mask_result (exe.mask_result_exe),
    .old_vd      (exe.old_vd_exe),
    .mask        (exe.mask_exe),
    .vm          (exe.vm_exe),
    .is_mask_dst (exe.is_mask_dst_exe),
    .vtype       (exe.vtype),
    .vl          (exe.vl),
    .vstart      (exe.vstart),
    .merged      (merged)
  );

  // Assemble the entry stored on push (already merged)
  always_comb begin
    new_entry.data     = merged;
    new_entry.vd       = exe.vd_exe;
    new_entry.rd       = exe.rd_exe;
    new_entry.int_data = exe.int_data_result_exe;
    new_entry.is_v2i   = exe.is_v2i_exe;
  end

  // Drain FSM next-state and registered-output next values
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    vrf_we_d    = 1'b0;
    vrf_waddr_d = vrf_waddr_q;
    vrf_wdata_d = vrf_wdata_q;
    int_we_d    = 1'b0;
    int_waddr_d = int_waddr_q;
    int_wdata_d = int_wdata_q;
    case (state_q)
      WB_IDLE: begin
        if (push) begin
          state_d = WB_HEAD;
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_HEAD: begin
        // integer results never wait on the VRF port
        pop = head.is_v2i | vrf_ready;
        if (pop && head.is_v2i) begin
          int_we_d    = 1'b1;
          int_waddr_d = head.rd;
          int_wdata_d = head.int_data;
        end else if (pop) begin
          vrf_we_d    = 1'b1;
          vrf_waddr_d = head.vd;
          vrf_wdata_d = head.data;
        end else begin
          vrf_we_d = 1'b0;
        end
        if (pop && !push && (count_q == CNT_W'(1))) begin
          state_d = WB_IDLE;
        end else begin
          state_d = WB_HEAD;
        end
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  // FIFO storage, pointer and occupancy next values
  always_comb begin
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = new_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State, FIFO and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= WB_IDLE;
      vrf_we_q    <= 1'b0;
      vrf_waddr_q <= '0;
      vrf_wdata_q <= '0;
      int_we_q    <= 1'b0;
      int_waddr_q <= '0;
      int_wdata_q <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      vrf_we_q    <= vrf_we_d;
      vrf_waddr_q <= vrf_waddr_d;
      vrf_wdata_q <= vrf_wdata_d;
      int_we_q    <= int_we_d;
      int_waddr_q <= int_waddr_d;
      int_wdata_q <= int_wdata_d;
    end
  end

  assign vrf_we    = vrf_we_q;
  assign vrf_waddr = vrf_waddr_q;
  assign vrf_wdata = vrf_wdata_q;
  assign int_we    = int_we_q;
  assign int_waddr = int_waddr_q;
  assign int_wdata = int_wdata_q;

  // Forwarding view of the head; integer heads are not forwardable
  assign byp_valid = (state_q == WB_HEAD) & ~head.is_v2i;
  assign byp_vd    = byp_valid ? head.vd   : '0;
  assign byp_data  = byp_valid ? head.data : '0;

endmodule
